// File: rtl/mem_pkg.sv
// Shared types for the memory port initiator, its memory model and benches.
// Holds the FSM state encoding, the 4x16 vector lane type and default sizing.
// Pure declarations plus one request legality helper; no logic of its own.
package mem_pkg;

    // Number of addressable words when a design does not override it.
    localparam int MEM_WORDS_DEFAULT = 1024;

    // Vector accesses move four 16-bit lanes covering four consecutive words.
    localparam int VEC_LANES  = 4;
    localparam int LANE_WIDTH = 16;

    typedef logic [VEC_LANES-1:0][LANE_WIDTH-1:0] vec4x16_t;

    // Initiator FSM: IDLE accepts, ISSUE/WAIT drive the memory, RESP returns.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mem_port_state_t;

    // A request may reach the memory only when its word address lies inside
    // the array and, for vector accesses, the four-word group is aligned.
    function automatic logic req_is_legal(
        input logic [63:0] addr,
        input logic        vect,
        input int unsigned words
    );
        logic in_range;
        logic aligned;
        in_range = (addr < 64'(words));
        aligned  = !vect || (addr[1:0] == 2'b00);
        return in_range && aligned;
    endfunction

endpackage : mem_pkg

// File: rtl/mem_port_initiator.sv
// Single-outstanding memory port initiator: request -> memory strobes -> response.
// Latency: 2 cycles from accept to resp_valid when memory answers in ISSUE; 1 cycle for rejected requests.
// Backpressure: req_ready only in IDLE; response held until resp_ready; optional WAIT abort via MEM_PORT_TIMEOUT_EN.
module mem_port_initiator
    import mem_pkg::*;
#(
    parameter int MEM_WORDS      = MEM_WORDS_DEFAULT,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,

    // Pipeline request channel
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_vect,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  vec4x16_t    req_wvect,

    // Response channel
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output vec4x16_t    resp_rvect,
    output logic        resp_err,

    // Memory side
    output logic [63:0] mem_address,
    output logic [63:0] mem_data_in,
    output vec4x16_t    mem_vect_in,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_vect,
    input  logic [63:0] mem_data_out,
    input  vec4x16_t    mem_vect_out,
    input  logic        mem_valid
);

    // A zero timeout would abort every access before the memory could answer.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_port_initiator: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    mem_port_state_t state_q, state_d;

    // Memory-side registers double as the captured request fields: they are
    // loaded on accept and cleared the moment the access completes or aborts.
    logic [63:0] mem_address_q, mem_address_d;
    logic [63:0] mem_data_in_q, mem_data_in_d;
    vec4x16_t    mem_vect_in_q, mem_vect_in_d;
    logic        mem_read_q,    mem_read_d;
    logic        mem_write_q,   mem_write_d;
    logic        mem_vect_q,    mem_vect_d;

    logic        resp_valid_q,  resp_valid_d;
    logic        resp_err_q,    resp_err_d;
    logic [63:0] resp_rdata_q,  resp_rdata_d;
    vec4x16_t    resp_rvect_q,  resp_rvect_d;

`ifdef MEM_PORT_TIMEOUT_EN
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    logic req_legal;
    logic clear_mem;

    assign req_legal = req_is_legal(req_addr, req_vect, MEM_WORDS);

    // ------------------------------------------------------------------
    // Next-state and output computation
    // ------------------------------------------------------------------

    // FSM transitions, request capture, response formatting and strobe clearing.
    always_comb begin
        state_d       = state_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        mem_vect_in_d = mem_vect_in_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_vect_d    = mem_vect_q;
        resp_valid_d  = resp_valid_q;
        resp_err_d    = resp_err_q;
        resp_rdata_d  = resp_rdata_q;
        resp_rvect_d  = resp_rvect_q;
`ifdef MEM_PORT_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
`endif
        clear_mem     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // req_ready is high whenever IDLE is live, so req_valid alone accepts.
                if (req_valid) begin
                    if (req_legal) begin
                        state_d       = ST_ISSUE;
                        mem_address_d = req_addr;
                        mem_data_in_d = req_wdata;
                        mem_vect_in_d = req_wvect;
                        mem_vect_d    = req_vect;
                        mem_write_d   = req_write;
                        mem_read_d    = !req_write;
`ifdef MEM_PORT_TIMEOUT_EN
                        wait_cnt_d    = '0;
`endif
                    end else begin
                        // Rejected requests never touch the memory.
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        resp_rvect_d = '0;
                    end
                end
            end

            ST_ISSUE, ST_WAIT: begin
                if (mem_valid) begin
                    // Only loads return data, and only on the lanes the access used.
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = (mem_read_q && !mem_vect_q) ? mem_data_out : '0;
                    resp_rvect_d = (mem_read_q &&  mem_vect_q) ? mem_vect_out : '0;
                    clear_mem    = 1'b1;
                end else if (state_q == ST_ISSUE) begin
                    state_d = ST_WAIT;
                end
`ifdef MEM_PORT_TIMEOUT_EN
                else begin
                    // Count WAIT cycles; abort once the budget is spent.
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_d == TO_W'(TIMEOUT_CYCLES)) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        resp_rvect_d = '0;
                        clear_mem    = 1'b1;
                    end
                end
`endif
            end

            ST_RESP: begin
                // Payload stays frozen until the consumer takes it.
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                    resp_rvect_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes and address/data drop together when the access ends.
        if (clear_mem) begin
            mem_address_d = '0;
            mem_data_in_d = '0;
            mem_vect_in_d = '0;
            mem_read_d    = 1'b0;
            mem_write_d   = 1'b0;
            mem_vect_d    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Reset abandons any in-flight access: everything returns to zero/IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_vect_in_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_vect_q    <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
            resp_rvect_q  <= '0;
`ifdef MEM_PORT_TIMEOUT_EN
            wait_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_vect_in_q <= mem_vect_in_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_vect_q    <= mem_vect_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_rvect_q  <= resp_rvect_d;
`ifdef MEM_PORT_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // req_ready is gated by rst_n so it reads 0 while reset is held, yet is
    // already 1 when reset lifts, letting the very first edge accept.
    assign req_ready   = rst_n && (state_q == ST_IDLE);

    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_rvect  = resp_rvect_q;

    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_vect_in = mem_vect_in_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_vect    = mem_vect_q;

endmodule : mem_port_initiator

// File: tb/tb_mem_port_initiator.sv
// Bench for mem_port_initiator: drives requests, acts as the memory, checks responses.
// Expected results come from a word-level model of memory contents and the accept/reject rules.
// Memory answer delay and response backpressure are varied per transaction.
module tb_mem_port_initiator;
    import mem_pkg::*;

    localparam int MEM_WORDS      = 1024;
    localparam int TIMEOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_vect = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    vec4x16_t    req_wvect = '0;
    logic        req_ready;
    logic        resp_valid, resp_err;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    vec4x16_t    resp_rvect;
    logic [63:0] mem_address, mem_data_in;
    vec4x16_t    mem_vect_in;
    logic        mem_read, mem_write, mem_vect;
    logic [63:0] mem_data_out = '0;
    vec4x16_t    mem_vect_out = '0;
    logic        mem_valid = 1'b0;

    always #5 clk = ~clk;

    mem_port_initiator #(
        .MEM_WORDS      (MEM_WORDS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_vect     (req_vect),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wvect    (req_wvect),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_rvect   (resp_rvect),
        .resp_err     (resp_err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_vect_in  (mem_vect_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_vect     (mem_vect),
        .mem_data_out (mem_data_out),
        .mem_vect_out (mem_vect_out),
        .mem_valid    (mem_valid)
    );

    int checks = 0;
    int errors = 0;

    // Reference contents (updated from requests) and the bench memory (updated from DUT strobes).
    logic [63:0] ref_scal [longint];
    vec4x16_t    ref_vec  [longint];
    logic [63:0] mem_scal [longint];
    vec4x16_t    mem_vec  [longint];

    logic any_out;
    assign any_out = req_ready | resp_valid | resp_err | (|resp_rdata) | (|resp_rvect) |
                     (|mem_address) | (|mem_data_in) | (|mem_vect_in) |
                     mem_read | mem_write | mem_vect;

    // Contents of never-written locations.
    function automatic logic [63:0] dflt_word(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
    endfunction

    function automatic vec4x16_t dflt_vec(input logic [63:0] a);
        vec4x16_t v;
        for (int i = 0; i < 4; i++) v[i] = (a[15:0] ^ 16'hC3C3) + 16'(i);
        return v;
    endfunction

    // Observations of the last transaction.
    logic        obs_acc, obs_to, obs_rd, obs_wr, obs_err, obs_end_valid, obs_end_rdy;
    int          obs_lat, obs_strobes, obs_strobe_bad, obs_rdy_busy, obs_hold_bad;
    logic [63:0] obs_rdata;
    vec4x16_t    obs_rvect;

    // Present one request now (caller is away from a rising edge), play memory, collect observations.
    // mdelay: extra strobe cycles before mem_valid (-1 = never); rdelay: cycles resp_ready stays low.
    task automatic run_txn(input logic w, input logic v, input logic [63:0] a,
                           input logic [63:0] wd, input vec4x16_t wv,
                           input int mdelay, input int rdelay);
        int c, k, rc;
        logic done;
        obs_to = 1'b0; obs_rd = 1'b0; obs_wr = 1'b0; obs_err = 1'b0;
        obs_lat = 0; obs_strobes = 0; obs_strobe_bad = 0; obs_rdy_busy = 0; obs_hold_bad = 0;
        obs_rdata = '0; obs_rvect = '0;
        req_valid = 1'b1; req_write = w; req_vect = v; req_addr = a;
        req_wdata = wd; req_wvect = wv;
        #1;
        obs_acc = req_ready;
        @(posedge clk); #1;
        // Scramble request inputs so the DUT must rely on its captured copy.
        req_valid = 1'b0; req_write = ~w; req_vect = ~v;
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
        req_wvect = {$urandom, $urandom};
        c = 1; k = 0; rc = 0; done = 1'b0;
        while (!done && c <= 200) begin
            if (req_ready) obs_rdy_busy++;
            mem_data_out = {$urandom, $urandom};
            mem_vect_out = {$urandom, $urandom};
            if (mem_read || mem_write) begin
                k++;
                if (mem_address !== a || mem_data_in !== wd || mem_vect_in !== wv ||
                    mem_vect !== v || mem_write !== w || mem_read !== !w) obs_strobe_bad++;
                if (mem_read)  obs_rd = 1'b1;
                if (mem_write) obs_wr = 1'b1;
                if (mdelay >= 0 && k == mdelay + 1) begin
                    mem_valid = 1'b1;
                    if (mem_write) begin
                        if (mem_vect) mem_vec[longint'(mem_address)] = mem_vect_in;
                        else          mem_scal[longint'(mem_address)] = mem_data_in;
                    end else if (mem_vect) begin
                        mem_vect_out = mem_vec.exists(longint'(mem_address)) ?
                                       mem_vec[longint'(mem_address)] : dflt_vec(mem_address);
                    end else begin
                        mem_data_out = mem_scal.exists(longint'(mem_address)) ?
                                       mem_scal[longint'(mem_address)] : dflt_word(mem_address);
                    end
                end else begin
                    mem_valid = 1'b0;
                end
            end else begin
                // No access in flight: stray mem_valid pulses must be ignored.
                mem_valid = 1'($urandom_range(0, 1));
            end
            if (resp_valid) begin
                rc++;
                if (obs_lat == 0) begin
                    obs_lat = c; obs_err = resp_err; obs_rdata = resp_rdata; obs_rvect = resp_rvect;
                end else if ({resp_err, resp_rdata, resp_rvect} !== {obs_err, obs_rdata, obs_rvect}) begin
                    obs_hold_bad++;
                end
                resp_ready = (rc > rdelay);
                done = resp_ready;
            end else begin
                if (obs_lat != 0) obs_hold_bad++;
                resp_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            c++;
        end
        obs_strobes = k;
        obs_to = !done;
        mem_valid = 1'b0;
        resp_ready = 1'b0;
        obs_end_valid = resp_valid;
        obs_end_rdy = req_ready;
    endtask

    task automatic test_reset;
        req_valid = 1'b1; mem_valid = 1'b1; resp_ready = 1'b1; req_addr = 64'd8;
        #3;
        checks++;
        if (any_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero (%b), required all 0", any_out);
        end
        @(posedge clk); #2;
        checks++;
        if (any_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: some output nonzero (%b) after edge in reset, required all 0", any_out);
        end
        req_valid = 1'b0; mem_valid = 1'b0; resp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: req_ready=%b resp_valid=%b, required 1 and 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_vector_store;
        vec4x16_t wv;
        wv = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        ref_vec[512] = wv;
        run_txn(1'b1, 1'b1, 64'd512, 64'd0, wv, 0, 0);
        checks++;
        if (obs_to || obs_acc !== 1'b1) begin
            errors++;
            $display("FAIL vst_accept: acc=%b timeout=%b, required 1 and 0", obs_acc, obs_to);
        end
        checks++;
        if (obs_lat != 2) begin
            errors++;
            $display("FAIL vst_latency: got %0d cycles, required 2", obs_lat);
        end
        checks++;
        if (obs_strobes != 1 || !obs_wr || obs_rd || obs_strobe_bad != 0) begin
            errors++;
            $display("FAIL vst_strobes: cycles=%0d wr=%b rd=%b bad=%0d, required 1/1/0/0",
                     obs_strobes, obs_wr, obs_rd, obs_strobe_bad);
        end
        checks++;
        if ({obs_err, obs_rdata, obs_rvect} !== '0) begin
            errors++;
            $display("FAIL vst_payload: err=%b rdata=%h rvect=%h, required all 0", obs_err, obs_rdata, obs_rvect);
        end
    endtask

    task automatic test_vector_load;
        run_txn(1'b0, 1'b1, 64'd512, 64'd0, '0, 0, 0);
        checks++;
        if (obs_lat != 2 || !obs_rd || obs_wr || obs_strobe_bad != 0) begin
            errors++;
            $display("FAIL vld_strobes: lat=%0d rd=%b wr=%b bad=%0d, required 2/1/0/0", obs_lat, obs_rd, obs_wr, obs_strobe_bad);
        end
        checks++;
        if (obs_rvect !== ref_vec[512] || obs_rdata !== 64'd0 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL vld_data: rvect=%h rdata=%h err=%b, required %h/0/0", obs_rvect, obs_rdata, obs_err, ref_vec[512]);
        end
    endtask

    task automatic test_out_of_range;
        run_txn(1'b0, 1'b0, 64'd2000, 64'd0, '0, 0, 0);
        checks++;
        if (obs_err !== 1'b1 || obs_lat != 1) begin
            errors++;
            $display("FAIL oor_resp: err=%b lat=%0d, required 1 and 1", obs_err, obs_lat);
        end
        checks++;
        if (obs_rd || obs_wr || obs_strobes != 0 || {obs_rdata, obs_rvect} !== '0) begin
            errors++;
            $display("FAIL oor_strobes: rd=%b wr=%b cycles=%0d payload=%h, required no strobes and 0",
                     obs_rd, obs_wr, obs_strobes, {obs_rdata, obs_rvect});
        end
    endtask

    task automatic test_misaligned;
        run_txn(1'b1, 1'b1, 64'd514, 64'd0, {$urandom, $urandom}, 0, 1);
        checks++;
        if (obs_err !== 1'b1 || obs_lat != 1 || obs_strobes != 0 || obs_hold_bad != 0) begin
            errors++;
            $display("FAIL misaligned: err=%b lat=%0d strobes=%0d hold=%0d, required 1/1/0/0",
                     obs_err, obs_lat, obs_strobes, obs_hold_bad);
        end
    endtask

    task automatic test_store_stall;
        ref_scal[4] = 64'h1234_5678_9ABC_DEF0;
        run_txn(1'b1, 1'b0, 64'd4, 64'h1234_5678_9ABC_DEF0, '0, 5, 3);
        checks++;
        if (obs_strobes != 6 || obs_strobe_bad != 0 || !obs_wr || obs_rd) begin
            errors++;
            $display("FAIL stall_strobes: cycles=%0d bad=%0d wr=%b rd=%b, required 6/0/1/0",
                     obs_strobes, obs_strobe_bad, obs_wr, obs_rd);
        end
        checks++;
        if (obs_lat != 7 || obs_hold_bad != 0 || obs_rdy_busy != 0) begin
            errors++;
            $display("FAIL stall_resp: lat=%0d hold=%0d rdy_busy=%0d, required 7/0/0", obs_lat, obs_hold_bad, obs_rdy_busy);
        end
        checks++;
        if (obs_end_valid !== 1'b0 || obs_end_rdy !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: resp_valid=%b req_ready=%b after handshake, required 0 and 1", obs_end_valid, obs_end_rdy);
        end
    endtask

    task automatic test_back_to_back;
        run_txn(1'b0, 1'b0, 64'd4, 64'd0, '0, 1, 0);
        checks++;
        if (obs_acc !== 1'b1 || obs_lat != 3 || obs_rdata !== ref_scal[4] || obs_rvect !== '0) begin
            errors++;
            $display("FAIL b2b_load: acc=%b lat=%0d rdata=%h rvect=%h, required 1/3/%h/0",
                     obs_acc, obs_lat, obs_rdata, obs_rvect, ref_scal[4]);
        end
        run_txn(1'b0, 1'b0, 64'd100, 64'd0, '0, 0, 0);
        checks++;
        if (obs_acc !== 1'b1 || obs_lat != 2 || obs_rdata !== dflt_word(64'd100)) begin
            errors++;
            $display("FAIL b2b_second: acc=%b lat=%0d rdata=%h, required 1/2/%h",
                     obs_acc, obs_lat, obs_rdata, dflt_word(64'd100));
        end
    endtask

    task automatic test_reset_in_wait;
        logic [63:0] exp;
        req_valid = 1'b1; req_write = 1'b0; req_vect = 1'b0; req_addr = 64'd8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_setup: mem_read=%b in WAIT, required 1", mem_read);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (any_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_async: some output nonzero (%b), required all 0", any_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_release: req_ready=%b resp_valid=%b, required 1 and 0", req_ready, resp_valid);
        end
        exp = ref_scal.exists(8) ? ref_scal[8] : dflt_word(64'd8);
        run_txn(1'b0, 1'b0, 64'd8, 64'd0, '0, 0, 0);
        checks++;
        if (obs_acc !== 1'b1 || obs_lat != 2 || obs_rdata !== exp || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_first: acc=%b lat=%0d rdata=%h err=%b, required 1/2/%h/0",
                     obs_acc, obs_lat, obs_rdata, obs_err, exp);
        end
    endtask

    task automatic test_random;
        logic w, v, e;
        logic [63:0] a, wd, er;
        vec4x16_t wv, ev;
        int md, rd, sel;
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            if (sel == 0)      a = {32'h1, 32'($urandom)};
            else if (sel == 1) a = 64'($urandom_range(1000, 1100));
            else               a = 64'($urandom_range(0, 15) * 4 + (v ? (($urandom_range(0, 4) == 0) ? 2 : 0)
                                                                  : $urandom_range(0, 3)));
            wd = {$urandom, $urandom};
            wv = {$urandom, $urandom};
            md = $urandom_range(0, 4);
            rd = $urandom_range(0, 3);
            e  = (a >= 64'(MEM_WORDS)) || (v && a[1:0] != 2'b00);
            er = '0;
            ev = '0;
            if (!e && !w) begin
                if (v) ev = ref_vec.exists(longint'(a)) ? ref_vec[longint'(a)] : dflt_vec(a);
                else   er = ref_scal.exists(longint'(a)) ? ref_scal[longint'(a)] : dflt_word(a);
            end
            if (!e && w) begin
                if (v) ref_vec[longint'(a)] = wv;
                else   ref_scal[longint'(a)] = wd;
            end
            run_txn(w, v, a, wd, wv, md, rd);
            checks++;
            if (obs_to || obs_acc !== 1'b1 || obs_lat != (e ? 1 : md + 2)) begin
                errors++;
                $display("FAIL rand_latency[%0d]: acc=%b timeout=%b lat=%0d, required 1/0/%0d",
                         n, obs_acc, obs_to, obs_lat, e ? 1 : md + 2);
            end
            checks++;
            if (obs_strobes != (e ? 0 : md + 1) || obs_strobe_bad != 0 || obs_rdy_busy != 0) begin
                errors++;
                $display("FAIL rand_strobes[%0d]: cycles=%0d bad=%0d rdy_busy=%0d, required %0d/0/0",
                         n, obs_strobes, obs_strobe_bad, obs_rdy_busy, e ? 0 : md + 1);
            end
            checks++;
            if ({obs_err, obs_rdata, obs_rvect} !== {e, er, ev} || obs_hold_bad != 0) begin
                errors++;
                $display("FAIL rand_payload[%0d]: err=%b rdata=%h rvect=%h hold=%0d, required %b/%h/%h/0",
                         n, obs_err, obs_rdata, obs_rvect, obs_hold_bad, e, er, ev);
            end
            checks++;
            if (obs_end_valid !== 1'b0 || obs_end_rdy !== 1'b1) begin
                errors++;
                $display("FAIL rand_idle[%0d]: resp_valid=%b req_ready=%b, required 0 and 1", n, obs_end_valid, obs_end_rdy);
            end
        end
    endtask

`ifdef MEM_PORT_TIMEOUT_EN
    task automatic test_timeout;
        run_txn(1'b0, 1'b0, 64'd20, 64'd0, '0, -1, 0);
        checks++;
        if (obs_err !== 1'b1 || obs_lat != TIMEOUT_CYCLES + 2 || {obs_rdata, obs_rvect} !== '0) begin
            errors++;
            $display("FAIL timeout_resp: err=%b lat=%0d payload=%h, required 1/%0d/0",
                     obs_err, obs_lat, {obs_rdata, obs_rvect}, TIMEOUT_CYCLES + 2);
        end
        checks++;
        if (obs_strobes != TIMEOUT_CYCLES + 1) begin
            errors++;
            $display("FAIL timeout_strobes: strobe cycles=%0d, required %0d", obs_strobes, TIMEOUT_CYCLES + 1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_vector_store();
        test_vector_load();
        test_out_of_range();
        test_misaligned();
        test_store_stall();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
`ifdef MEM_PORT_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation exceeded 500000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_port_initiator
